blake2_ctrl: RTL and testbench

BLAKE2_CTRL -- requirements
Module: blake2_ctrl

---
 rtl/blake2_pkg.sv | 26 ++
 rtl/blake2_round_cnt.sv | 39 +++
 rtl/blake2_ctrl.sv | 139 +++++++++++++
 tb/tb_blake2_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blake2_pkg.sv
// Shared constants, state encoding and parameter-block checks for the BLAKE2 controller.
package blake2_pkg;

    localparam int unsigned NB_ROUND    = 10;
    localparam int unsigned NB_G        = 8;
    localparam int unsigned BLOCK_BYTES = 64;
    localparam int unsigned KEY_MAX     = 32;
    localparam int unsigned NN_MAX      = 32;

    localparam logic [5:0] LAST_IDX = 6'(BLOCK_BYTES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StInit,
        StRound,
        StUpdate,
        StDone
    } state_e;

    // Digest length must be 1..NN_MAX and key length at most KEY_MAX.
    function automatic logic params_bad(logic [7:0] kk, logic [7:0] nn);
        return (nn == 8'd0) || (nn > 8'(NN_MAX)) || (kk > 8'(KEY_MAX));
    endfunction

endpackage

// File: rtl/blake2_round_cnt.sv
// Round / G-step counter: walks g_idx 0..NB_G-1 inside each round, rounds 0..NB_ROUND-1.
module blake2_round_cnt #(
    parameter int unsigned NB_ROUND = blake2_pkg::NB_ROUND,
    parameter int unsigned NB_G     = blake2_pkg::NB_G
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       start,
    input  logic       enable,
    output logic [3:0] round,
    output logic [2:0] g_idx,
    output logic       last
);

    logic g_last;
    logic round_last;

    assign g_last     = (g_idx == 3'(NB_G - 1));
    assign round_last = (round == 4'(NB_ROUND - 1));
    assign last       = g_last && round_last;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            round <= 4'd0;
            g_idx <= 3'd0;
        end else if (start) begin
            round <= 4'd0;
            g_idx <= 3'd0;
        end else if (enable) begin
            if (g_last) begin
                g_idx <= 3'd0;
                round <= round_last ? 4'd0 : round + 4'd1;
            end else begin
                g_idx <= g_idx + 3'd1;
            end
        end
    end

endmodule

// File: rtl/blake2_ctrl.sv
// BLAKE2 compression sequencer: tracks block fill, byte offset and final flag, and
// steps the datapath through v init, the G schedule and the h update.
module blake2_ctrl #(
    parameter int unsigned NB_ROUND = blake2_pkg::NB_ROUND,
    parameter int unsigned NB_G     = blake2_pkg::NB_G
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic [7:0]  kk_i,
    input  logic [7:0]  nn_i,
    input  logic [63:0] ll_i,
    input  logic        data_v_i,
    input  logic [5:0]  data_idx_i,
    input  logic        block_first_i,
    input  logic        block_last_i,
    output logic        h_init_o,
    output logic        v_init_o,
    output logic        g_v_o,
    output logic [3:0]  round_o,
    output logic [2:0]  g_idx_o,
    output logic        h_update_o,
    output logic [63:0] t_o,
    output logic        f_o,
    output logic        hash_finished_o,
    output logic        err_o
);

    import blake2_pkg::state_e;
    import blake2_pkg::StIdle;
    import blake2_pkg::StFill;
    import blake2_pkg::StInit;
    import blake2_pkg::StRound;
    import blake2_pkg::StUpdate;
    import blake2_pkg::StDone;
    import blake2_pkg::BLOCK_BYTES;
    import blake2_pkg::LAST_IDX;
    import blake2_pkg::params_bad;

    state_e      state_q;
    logic        cnt_start;
    logic        cnt_enable;
    logic        cnt_last;
    logic        busy;
    logic        bad_params;
    logic [63:0] t_base;
    logic [63:0] t_final;

    assign busy       = state_q inside {StInit, StRound, StUpdate, StDone};
    assign bad_params = params_bad(kk_i, nn_i);
    // A first byte restarts the offset from zero, otherwise it accumulates.
    assign t_base     = block_first_i ? 64'd0 : t_o;
    // The key block counts as one full block of message bytes.
    assign t_final    = ll_i + ((kk_i != 8'd0) ? 64'(BLOCK_BYTES) : 64'd0);
    assign cnt_start  = (state_q == StInit);
    assign cnt_enable = (state_q == StRound);

    blake2_round_cnt #(
        .NB_ROUND (NB_ROUND),
        .NB_G     (NB_G)
    ) u_round_cnt (
        .clk    (clk),
        .nreset (nreset),
        .start  (cnt_start),
        .enable (cnt_enable),
        .round  (round_o),
        .g_idx  (g_idx_o),
        .last   (cnt_last)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q         <= StIdle;
            t_o             <= 64'd0;
            f_o             <= 1'b0;
            err_o           <= 1'b0;
            h_init_o        <= 1'b0;
            v_init_o        <= 1'b0;
            g_v_o           <= 1'b0;
            h_update_o      <= 1'b0;
            hash_finished_o <= 1'b0;
        end else begin
            h_init_o        <= 1'b0;
            v_init_o        <= 1'b0;
            g_v_o           <= 1'b0;
            h_update_o      <= 1'b0;
            hash_finished_o <= 1'b0;
            if (data_v_i && busy) begin
                err_o <= 1'b1;
            end
            unique case (state_q)
                StIdle, StFill: begin
                    if (data_v_i) begin
                        // An invalid parameter block aborts back to idle, even on a restart.
                        if (block_first_i && bad_params) begin
                            err_o   <= 1'b1;
                            state_q <= StIdle;
                        end else if (block_first_i || state_q == StFill) begin
                            h_init_o <= block_first_i;
                            if (data_idx_i == LAST_IDX) begin
                                f_o      <= block_last_i;
                                t_o      <= block_last_i ? t_final
                                                         : t_base + 64'(BLOCK_BYTES);
                                v_init_o <= 1'b1;
                                state_q  <= StInit;
                            end else begin
                                t_o     <= t_base;
                                state_q <= StFill;
                            end
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                end
                StInit: begin
                    g_v_o   <= 1'b1;
                    state_q <= StRound;
                end
                StRound: begin
                    if (cnt_last) begin
                        h_update_o <= 1'b1;
                        state_q    <= StUpdate;
                    end else begin
                        g_v_o <= 1'b1;
                    end
                end
                StUpdate: begin
                    hash_finished_o <= f_o;
                    state_q         <= f_o ? StDone : StFill;
                end
                StDone: begin
                    f_o     <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_blake2_ctrl.sv
// Scoreboard bench for blake2_ctrl: the driver predicts pulse events from message
// parameters, and a negedge monitor pops and checks them as the DUT produces them.
module tb_blake2_ctrl;

    localparam int NB_ROUND = 10;
    localparam int NB_G     = 8;
    localparam int N_STEPS  = NB_ROUND * NB_G;
    localparam int LAT      = N_STEPS + 3;

    typedef struct {
        int              kind;
        longint unsigned t;
        bit              f;
        int              cyc;
    } ev_t;

    logic        clk = 1'b0;
    logic        nreset;
    logic [7:0]  kk_i;
    logic [7:0]  nn_i;
    logic [63:0] ll_i;
    logic        data_v_i;
    logic [5:0]  data_idx_i;
    logic        block_first_i;
    logic        block_last_i;
    logic        h_init_o;
    logic        v_init_o;
    logic        g_v_o;
    logic [3:0]  round_o;
    logic [2:0]  g_idx_o;
    logic        h_update_o;
    logic [63:0] t_o;
    logic        f_o;
    logic        hash_finished_o;
    logic        err_o;

    int  n_cmp = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  gv_cnt = 0;
    bit  exp_err = 1'b0;
    ev_t q[$];

    blake2_ctrl #(
        .NB_ROUND (NB_ROUND),
        .NB_G     (NB_G)
    ) dut (
        .clk             (clk),
        .nreset          (nreset),
        .kk_i            (kk_i),
        .nn_i            (nn_i),
        .ll_i            (ll_i),
        .data_v_i        (data_v_i),
        .data_idx_i      (data_idx_i),
        .block_first_i   (block_first_i),
        .block_last_i    (block_last_i),
        .h_init_o        (h_init_o),
        .v_init_o        (v_init_o),
        .g_v_o           (g_v_o),
        .round_o         (round_o),
        .g_idx_o         (g_idx_o),
        .h_update_o      (h_update_o),
        .t_o             (t_o),
        .f_o             (f_o),
        .hash_finished_o (hash_finished_o),
        .err_o           (err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input longint unsigned t, input bit f, input int at);
        ev_t e;
        e.kind = kind;
        e.t    = t;
        e.f    = f;
        e.cyc  = at;
        q.push_back(e);
    endtask

    task automatic check_ev(input int kind);
        ev_t e;
        n_cmp++;
        if (q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", kind, cyc);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.t != t_o || e.f != f_o) begin
                n_err++;
                $display("FAIL event: got kind %0d cyc %0d t %0d f %0b expected kind %0d cyc %0d t %0d f %0b",
                         kind, cyc, t_o, f_o, e.kind, e.cyc, e.t, e.f);
            end
        end
    endtask

    // Monitor: every pulse consumes one predicted event; G steps must run in order.
    always @(negedge clk) begin
        if (nreset) begin
            if (h_init_o) check_ev(0);
            if (v_init_o) begin
                check_ev(1);
                gv_cnt = 0;
            end
            if (g_v_o) begin
                chk("g_step", longint'(round_o) * NB_G + longint'(g_idx_o), gv_cnt);
                gv_cnt++;
            end
            if (h_update_o) begin
                chk("g_count", gv_cnt, N_STEPS);
                check_ev(2);
            end
            if (hash_finished_o) check_ev(3);
        end
    end

    task automatic put_byte(input int idx, input bit first, input bit last, input bit gap,
                            output int at);
        data_v_i = 1'b0;
        if (gap) begin
            while ($urandom_range(3) == 0) @(negedge clk);
        end
        data_v_i      = 1'b1;
        data_idx_i    = 6'(idx);
        block_first_i = first;
        block_last_i  = last;
        at            = cyc;
    endtask

    task automatic wait_for(input bit want_done);
        bit seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            seen = want_done ? hash_finished_o : h_update_o;
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: got no pulse expected %s", want_done ? "hash_finished" : "h_update");
        end
        @(negedge clk);
    endtask

    // Message-level model: block count from ll/kk, offsets and flags from the BLAKE2 rules.
    task automatic run_msg(input logic [7:0] kk, input logic [7:0] nn,
                           input longint unsigned ll, input bit inject);
        int nblk;
        int at;
        bit last;
        longint unsigned t_exp;
        nblk = int'((ll + 63) / 64) + ((kk != 0) ? 1 : 0);
        if (nblk == 0) nblk = 1;
        kk_i = kk;
        nn_i = nn;
        ll_i = ll;
        for (int b = 0; b < nblk; b++) begin
            last = (b == nblk - 1);
            for (int idx = 0; idx < 64; idx++) begin
                put_byte(idx, b == 0 && idx == 0, last, 1'b1, at);
                if (b == 0 && idx == 0) push(0, 0, 1'b0, at + 1);
                if (idx == 63) begin
                    t_exp = last ? ll + ((kk != 0) ? 64 : 0) : longint'(b + 1) * 64;
                    push(1, t_exp, last, at + 1);
                    push(2, t_exp, last, at + LAT - 1);
                    if (last) push(3, t_exp, 1'b1, at + LAT);
                end
                @(negedge clk);
                data_v_i = 1'b0;
            end
            if (last && inject) begin
                // Stray byte lands while G step 20 is in progress.
                repeat (21) @(negedge clk);
                data_v_i      = 1'b1;
                data_idx_i    = 6'($urandom_range(63));
                block_first_i = 1'b0;
                block_last_i  = 1'b0;
                exp_err       = 1'b1;
                @(negedge clk);
                data_v_i = 1'b0;
            end
            wait_for(last);
        end
        chk("err_after_msg", err_o, exp_err);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2 nreset = 1'b0;
        q.delete();
        exp_err = 1'b0;
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
    endtask

    task automatic bad_start(input logic [7:0] kk, input logic [7:0] nn);
        int at;
        apply_reset();
        chk("err_cleared", err_o, 0);
        kk_i = kk;
        nn_i = nn;
        ll_i = 64'd5;
        put_byte(0, 1'b1, 1'b1, 1'b0, at);
        exp_err = 1'b1;
        @(negedge clk);
        data_v_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("err_bad_params", err_o, exp_err);
        chk("t_bad_params", t_o, 0);
    endtask

    initial begin
        int at;
        bit found;
        nreset        = 1'b0;
        kk_i          = 8'd0;
        nn_i          = 8'd32;
        ll_i          = 64'd0;
        data_v_i      = 1'b0;
        data_idx_i    = 6'd0;
        block_first_i = 1'b0;
        block_last_i  = 1'b0;
        #1;
        chk("rst_h_init", h_init_o, 0);
        chk("rst_g_v", g_v_o, 0);
        chk("rst_t", t_o, 0);
        chk("rst_f", f_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_round", round_o, 0);
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);

        run_msg(8'd0, 8'd32, 64'd3, 1'b0);
        run_msg(8'd0, 8'd32, 64'd100, 1'b0);
        run_msg(8'd32, 8'd32, 64'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            run_msg(($urandom_range(1) == 1) ? 8'($urandom_range(1, 32)) : 8'd0,
                    8'($urandom_range(1, 32)), longint'($urandom_range(0, 200)), 1'b0);
        end
        run_msg(8'd0, 8'd16, 64'd40, 1'b1);
        run_msg(8'($urandom_range(0, 32)), 8'd32, longint'($urandom_range(0, 130)), 1'b0);

        bad_start(8'd0, 8'd0);
        bad_start(8'd33, 8'd16);
        bad_start(8'd0, 8'd33);

        // Reset in the middle of round 4 aborts the compression.
        apply_reset();
        kk_i = 8'd0;
        nn_i = 8'd32;
        ll_i = 64'd10;
        for (int idx = 0; idx < 64; idx++) begin
            put_byte(idx, idx == 0, 1'b1, 1'b0, at);
            if (idx == 0) push(0, 0, 1'b0, at + 1);
            if (idx == 63) push(1, 64'd10, 1'b1, at + 1);
            @(negedge clk);
            data_v_i = 1'b0;
        end
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (g_v_o && round_o == 4'd4) found = 1'b1;
            else @(negedge clk);
        end
        chk("reach_round4", found, 1);
        #2 nreset = 1'b0;
        #1;
        chk("mid_rst_g_v", g_v_o, 0);
        chk("mid_rst_round", round_o, 0);
        chk("mid_rst_g_idx", g_idx_o, 0);
        chk("mid_rst_t", t_o, 0);
        chk("mid_rst_f", f_o, 0);
        chk("mid_rst_pending", q.size(), 0);
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        repeat (120) @(negedge clk);
        chk("post_rst_err", err_o, 0);
        chk("post_rst_g_v", g_v_o, 0);
        put_byte(5, 1'b0, 1'b0, 1'b0, at);
        @(negedge clk);
        data_v_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_no_first_err", err_o, 1);
        repeat (5) @(negedge clk);
        chk("final_pending", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
